// File: rtl/spike_pkg.sv
// Shared defaults and types for the spiking soma array.
package spike_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_W      = 14;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_REFRAC = 3;

  typedef logic [DEF_W-1:0] volt_t;

  // Post-spike membrane handling: discard the residue, or carry the overshoot forward.
  typedef enum logic [0:0] {
    RST_ZERO     = 1'b0,
    RST_SUBTRACT = 1'b1
  } reset_mode_e;

endpackage

// File: rtl/spike_soma_ch.sv
// One soma channel: saturating add, threshold compare, refractory counter, voltage register.
module spike_soma_ch
  import spike_pkg::*;
#(
  parameter int          W          = DEF_W,
  parameter int          REFRAC     = DEF_REFRAC,
  parameter reset_mode_e RESET_MODE = RST_ZERO
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic [W-1:0] sum_in,
  input  logic [W-1:0] decay,
  input  logic [W-1:0] threshold,
  output logic         fire,
  output logic [W-1:0] voltage,
  output logic         spike,
  output logic         refrac
);

  localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);

  logic [RW-1:0] refrac_cnt;
  logic [RW-1:0] refrac_cnt_nxt;
  logic [W:0]    sum_raw;
  logic [W-1:0]  sum_sat;
  logic [W-1:0]  voltage_nxt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sum_raw        = {1'b0, sum_in} + {1'b0, decay};
    sum_sat        = sum_raw[W] ? '1 : sum_raw[W-1:0];
    fire           = valid && (refrac_cnt == '0) && (sum_sat >= threshold);
    voltage_nxt    = voltage;
    refrac_cnt_nxt = refrac_cnt;
    if (valid) begin
      if (refrac_cnt != '0) begin
        voltage_nxt    = '0;
        refrac_cnt_nxt = refrac_cnt - 1'b1;
      end else if (fire) begin
        refrac_cnt_nxt = RW'(REFRAC);
        // sum_sat >= threshold here, so the subtraction cannot underflow.
        voltage_nxt    = (RESET_MODE == RST_SUBTRACT) ? (sum_sat - threshold) : '0;
      end else begin
        voltage_nxt = sum_sat;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      voltage    <= '0;
      refrac_cnt <= '0;
      spike      <= 1'b0;
      refrac     <= 1'b0;
    end else begin
      voltage    <= voltage_nxt;
      refrac_cnt <= refrac_cnt_nxt;
      spike      <= fire;
      refrac     <= (refrac_cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/spike_soma_array.sv
// NUM_CH independent soma channels plus a saturating global spike counter.
module spike_soma_array
  import spike_pkg::*;
#(
  parameter int          NUM_CH     = DEF_NUM_CH,
  parameter int          W          = DEF_W,
  parameter int          REFRAC     = DEF_REFRAC,
  parameter reset_mode_e RESET_MODE = RST_ZERO,
  parameter int          CNT_W      = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [NUM_CH*W-1:0] i_sum,
  input  logic [NUM_CH*W-1:0] i_cond_decay,
  input  logic [W-1:0]        i_threshold,
  input  logic                i_cnt_clr,
  output logic [NUM_CH*W-1:0] o_final_voltage,
  output logic [NUM_CH-1:0]   o_spike,
  output logic [NUM_CH-1:0]   o_refrac,
  output logic [CNT_W-1:0]    o_spike_count
);

  localparam int POP_W = $clog2(NUM_CH + 1);
  localparam int CW1   = CNT_W + 1;

  logic [NUM_CH-1:0] fire;
  logic [POP_W-1:0]  pop;
  logic [CNT_W:0]    cnt_sum;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    spike_soma_ch #(
      .W          (W),
      .REFRAC     (REFRAC),
      .RESET_MODE (RESET_MODE)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .valid     (i_valid),
      .sum_in    (i_sum[k*W +: W]),
      .decay     (i_cond_decay[k*W +: W]),
      .threshold (i_threshold),
      .fire      (fire[k]),
      .voltage   (o_final_voltage[k*W +: W]),
      .spike     (o_spike[k]),
      .refrac    (o_refrac[k])
    );
  end

  // Counting the pre-register fire vector keeps the count aligned with o_spike.
  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_CH; k++) pop = pop + POP_W'(fire[k]);
    cnt_sum = {1'b0, o_spike_count} + CW1'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset)          o_spike_count <= '0;
    else if (i_cnt_clr) o_spike_count <= CNT_W'(pop);
    else if (cnt_sum[CNT_W]) o_spike_count <= '1;
    else                o_spike_count <= cnt_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_spike_soma_array.sv
// Directed bench: default array, subtract-mode array, and a no-refractory narrow-counter array.
module tb_spike_soma_array;
  import spike_pkg::*;

  localparam int N = 4;
  localparam int W = 14;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_valid;
  logic [N*W-1:0]  i_sum;
  logic [N*W-1:0]  i_cond_decay;
  logic [W-1:0]    i_threshold;
  logic            i_cnt_clr;

  logic [N*W-1:0]  v0, v1, v2;
  logic [N-1:0]    s0, s1, s2;
  logic [N-1:0]    r0, r1, r2;
  logic [15:0]     c0, c1;
  logic [3:0]      c2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spike_soma_array #(.NUM_CH(N), .W(W), .REFRAC(3), .RESET_MODE(RST_ZERO), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_sum(i_sum), .i_cond_decay(i_cond_decay),
    .i_threshold(i_threshold), .i_cnt_clr(i_cnt_clr), .o_final_voltage(v0), .o_spike(s0),
    .o_refrac(r0), .o_spike_count(c0));

  spike_soma_array #(.NUM_CH(N), .W(W), .REFRAC(3), .RESET_MODE(RST_SUBTRACT), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_sum(i_sum), .i_cond_decay(i_cond_decay),
    .i_threshold(i_threshold), .i_cnt_clr(i_cnt_clr), .o_final_voltage(v1), .o_spike(s1),
    .o_refrac(r1), .o_spike_count(c1));

  spike_soma_array #(.NUM_CH(N), .W(W), .REFRAC(0), .RESET_MODE(RST_ZERO), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_sum(i_sum), .i_cond_decay(i_cond_decay),
    .i_threshold(i_threshold), .i_cnt_clr(i_cnt_clr), .o_final_voltage(v2), .o_spike(s2),
    .o_refrac(r2), .o_spike_count(c2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic volt_t ch(input logic [N*W-1:0] vec, input int k);
    return vec[k*W +: W];
  endfunction

  task automatic set_ch(input int k, input volt_t s, input volt_t d);
    i_sum[k*W +: W]        = s;
    i_cond_decay[k*W +: W] = d;
  endtask

  task automatic clear_inputs();
    i_sum = '0;
    i_cond_decay = '0;
    i_cnt_clr = 1'b0;
  endtask

  // One clock edge with the given valid level; outputs sampled 1 time unit later.
  task automatic step(input logic v);
    i_valid = v;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    i_valid = 1'b0;
    i_threshold = 14'h1300;
    clear_inputs();
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
    check("rst_volt",  v0, '0);
    check("rst_spike", s0, '0);
    check("rst_refr",  r0, '0);
    check("rst_cnt",   c0, '0);

    // 1: sub-threshold accumulate, then cross.
    set_ch(0, 14'h1000, 14'h0200);
    step(1'b1);
    check("t1_volt",  ch(v0, 0), 14'h1200);
    check("t1_nospk", s0, 4'h0);
    set_ch(0, 14'h1100, 14'h0200);
    step(1'b1);
    check("t1_spike", s0, 4'h1);
    check("t1_v0",    ch(v0, 0), 14'h0000);
    check("t1_refr",  r0, 4'h1);
    check("t1_cnt",   c0, 16'd1);
    check("t1_sub_v", ch(v1, 0), 14'h0000);
    check("t1_norefr_dut2", r2, 4'h0);

    // 2: refractory holds across idle gaps and lasts exactly 3 valid steps.
    set_ch(0, 14'h1300, 14'h0100);
    step(1'b0);
    check("t2_pulse_one", s0, 4'h0);
    check("t2_gap_refr",  r0, 4'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("t2_refr_nospk", s0, 4'h0);
      check("t2_refr_volt",  ch(v0, 0), 14'h0000);
      step(1'b0);
    end
    check("t2_refr_done", r0, 4'h0);
    step(1'b1);
    check("t2_respike", s0, 4'h1);
    check("t2_cnt",     c0, 16'd2);

    // 3: threshold at max fires only on saturated sum; clamp and subtract mode.
    do_reset();
    i_threshold = 14'h3FFF;
    set_ch(0, 14'h3FFE, 14'h0000);
    set_ch(1, 14'h3FFF, 14'h0001);
    step(1'b1);
    check("t3_maxthr_spk", s0, 4'h2);
    check("t3_maxthr_v0",  ch(v0, 0), 14'h3FFE);
    i_threshold = 14'h1300;
    set_ch(0, 14'h3000, 14'h2000);
    set_ch(1, 14'h0000, 14'h0000);
    step(1'b1);
    check("t3_clamp_spk", s0, 4'h1);
    check("t3_zero_v",    ch(v0, 0), 14'h0000);
    check("t3_sub_v",     ch(v1, 0), 14'h2CFF);
    check("t3_sub_spk",   s1, 4'h1);

    // 4: all channels cross together; clear coincident with two spikes.
    do_reset();
    for (int k = 0; k < N; k++) set_ch(k, 14'h1300, 14'h0000);
    step(1'b1);
    check("t4_all_spk", s0, 4'hF);
    check("t4_cnt4",    c0, 16'd4);
    do_reset();
    set_ch(2, 14'h1400, 14'h0000);
    set_ch(3, 14'h1300, 14'h0000);
    step(1'b1);
    check("t4_pre_cnt", c0, 16'd2);
    set_ch(0, 14'h1300, 14'h0000);
    set_ch(1, 14'h1300, 14'h0000);
    i_cnt_clr = 1'b1;
    step(1'b1);
    i_cnt_clr = 1'b0;
    check("t4_clr_spk", s0, 4'h3);
    check("t4_clr_cnt", c0, 16'd2);

    // 5: reset mid-step during refractory.
    do_reset();
    set_ch(0, 14'h1300, 14'h0000);
    set_ch(1, 14'h0100, 14'h0000);
    step(1'b1);
    check("t5_pre_v1", ch(v0, 1), 14'h0100);
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    check("t5_volt",  v0, '0);
    check("t5_spike", s0, '0);
    check("t5_refr",  r0, '0);
    check("t5_cnt",   c0, '0);
    step(1'b1);
    check("t5_respike", s0, 4'h1);

    // 6: zero threshold; REFRAC=0 instance spikes every cycle, 4-bit counter saturates.
    do_reset();
    i_threshold = 14'h0000;
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      check("t6_every_cycle", s2, 4'hF);
    end
    check("t6_cnt_sat",   c2, 4'hF);
    check("t6_refrac_cnt", c0, 16'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
